branch_target_buffer: RTL and testbench

//   Direct-mapped branch target buffer and next-PC selector; sits beside gshare in fetch.

---
 rtl/branch_pkg.sv | 31 +++
 rtl/btb_array.sv | 49 ++++
 rtl/branch_target_buffer.sv | 84 ++++++++
 tb/tb_branch_target_buffer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// ============================================================================
// branch_pkg : widths, BTB entry type and PC field extraction shared by fetch
// Revision   : 1.0
// ============================================================================
`default_nettype none

package branch_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int TAG_WIDTH   = 22;
  localparam int INDEX_WIDTH = 8;
  localparam int NUM_ENTRIES = 256;

  typedef struct packed {
    logic                  valid;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] target;
  } btb_entry_t;

  // Word-aligned index: pc[INDEX_WIDTH+1:2]
  function automatic logic [INDEX_WIDTH-1:0] pc_idx(input logic [DATA_WIDTH-1:0] pc);
    return INDEX_WIDTH'(pc >> 2);
  endfunction

  function automatic logic [TAG_WIDTH-1:0] pc_tag(input logic [DATA_WIDTH-1:0] pc);
    return TAG_WIDTH'(pc >> (DATA_WIDTH - TAG_WIDTH));
  endfunction

endpackage

`default_nettype wire

// File: rtl/btb_array.sv
// ============================================================================
// btb_array : direct-mapped BTB storage, async read, sync write, async valid clear
// Revision  : 1.0
// ============================================================================
`default_nettype none

module btb_array
  import branch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_wr_en,
  input  logic [INDEX_WIDTH-1:0] i_wr_idx,
  input  logic [TAG_WIDTH-1:0]   i_wr_tag,
  input  logic [DATA_WIDTH-1:0]  i_wr_target,
  input  logic [INDEX_WIDTH-1:0] i_rd_idx,
  output btb_entry_t             o_rd_entry
);

  logic [NUM_ENTRIES-1:0] r_valid;
  logic [TAG_WIDTH-1:0]   r_tag    [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]  r_target [NUM_ENTRIES];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Payload is never cleared; the valid bit alone qualifies an entry.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]    <= i_wr_tag;
      r_target[i_wr_idx] <= i_wr_target;
    end
  end

  always_comb begin
    o_rd_entry        = '0;
    o_rd_entry.valid  = r_valid[i_rd_idx];
    o_rd_entry.tag    = r_tag[i_rd_idx];
    o_rd_entry.target = r_target[i_rd_idx];
  end

endmodule

`default_nettype wire

// File: rtl/branch_target_buffer.sv
// ============================================================================
// branch_target_buffer : BTB lookup, one-deep allocation write stage, next-PC mux
//   Optional: BTB_BYPASS_EN lets lookups hit on the pending write-stage entry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_target_buffer
  import branch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  pred,
  input  logic                  update,
  input  logic                  actually_taken,
  input  logic [DATA_WIDTH-1:0] resolved_pc,
  input  logic [DATA_WIDTH-1:0] resolved_target,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] target,
  output logic [DATA_WIDTH-1:0] next_pc
);

  logic                   r_wb_valid;
  logic [INDEX_WIDTH-1:0] r_wb_idx;
  logic [TAG_WIDTH-1:0]   r_wb_tag;
  logic [DATA_WIDTH-1:0]  r_wb_target;

  logic [INDEX_WIDTH-1:0] w_idx;
  logic [TAG_WIDTH-1:0]   w_tag;
  btb_entry_t             w_rd;
  logic                   w_arr_match;
  logic                   w_wb_match;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wb_valid <= 1'b0;
    end else begin
      r_wb_valid <= update && actually_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (update && actually_taken) begin
      r_wb_idx    <= pc_idx(resolved_pc);
      r_wb_tag    <= pc_tag(resolved_pc);
      r_wb_target <= resolved_target;
    end
  end

  btb_array u_array (
    .clk         (clk),
    .rstn        (rstn),
    .i_wr_en     (r_wb_valid),
    .i_wr_idx    (r_wb_idx),
    .i_wr_tag    (r_wb_tag),
    .i_wr_target (r_wb_target),
    .i_rd_idx    (w_idx),
    .o_rd_entry  (w_rd)
  );

  assign w_idx       = pc_idx(pc);
  assign w_tag       = pc_tag(pc);
  assign w_arr_match = w_rd.valid && (w_rd.tag == w_tag);

`ifdef BTB_BYPASS_EN
  assign w_wb_match = r_wb_valid && (r_wb_idx == w_idx) && (r_wb_tag == w_tag);
`else
  assign w_wb_match = 1'b0;
`endif

  // pc == 0 marks an idle fetch slot and never hits.
  always_comb begin
    hit    = (w_wb_match || w_arr_match) && (pc != '0);
    target = '0;
    if (hit) begin
      target = w_wb_match ? r_wb_target : w_rd.target;
    end
    next_pc = (hit && pred) ? target : pc + DATA_WIDTH'(4);
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
// ============================================================================
// tb_branch_target_buffer : directed vectors for branch_target_buffer
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] pc;
  logic        pred;
  logic        update;
  logic        actually_taken;
  logic [31:0] resolved_pc;
  logic [31:0] resolved_target;
  logic        hit;
  logic [31:0] target;
  logic [31:0] next_pc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_target_buffer dut (
    .clk             (clk),
    .rstn            (rstn),
    .pc              (pc),
    .pred            (pred),
    .update          (update),
    .actually_taken  (actually_taken),
    .resolved_pc     (resolved_pc),
    .resolved_target (resolved_target),
    .hit             (hit),
    .target          (target),
    .next_pc         (next_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic lookup(input string tag, input logic [31:0] a, input logic p,
                        input logic eh, input logic [31:0] et, input logic [31:0] en);
    pc   = a;
    pred = p;
    #1;
    chk({tag, ".hit"},    {31'b0, hit}, {31'b0, eh});
    chk({tag, ".target"}, target, et);
    chk({tag, ".next"},   next_pc, en);
  endtask

  task automatic resolve(input logic tk, input logic [31:0] rpc, input logic [31:0] rt);
    update          = 1'b1;
    actually_taken  = tk;
    resolved_pc     = rpc;
    resolved_target = rt;
  endtask

  task automatic idle();
    update         = 1'b0;
    actually_taken = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; pc = 32'h1000; pred = 1'b1;
    idle(); resolved_pc = '0; resolved_target = '0;
    #12;
    lookup("rst_low", 32'h1000, 1'b1, 1'b0, 32'h0, 32'h1004);
    rstn = 1'b1;
    step();
    lookup("rst_rel", 32'h1000, 1'b1, 1'b0, 32'h0, 32'h1004);

    // Allocate 0x1000 -> 0x2000; edge N captures
    resolve(1'b1, 32'h1000, 32'h2000);
    step();
    idle();
`ifdef BTB_BYPASS_EN
    lookup("alloc_n1", 32'h1000, 1'b1, 1'b1, 32'h2000, 32'h2000);
`else
    lookup("alloc_n1", 32'h1000, 1'b1, 1'b0, 32'h0, 32'h1004);
`endif
    step();
    lookup("alloc_n2", 32'h1000, 1'b1, 1'b1, 32'h2000, 32'h2000);
    lookup("pred0",    32'h1000, 1'b0, 1'b1, 32'h2000, 32'h1004);

    // Alias on index 0 with a new tag
    resolve(1'b1, 32'h1400, 32'h3000);
    step(); idle(); step();
    lookup("alias_old", 32'h1000, 1'b1, 1'b0, 32'h0, 32'h1004);
    lookup("alias_new", 32'h1400, 1'b1, 1'b1, 32'h3000, 32'h3000);

    // Not-taken update leaves the entry alone
    resolve(1'b0, 32'h1400, 32'h9999);
    step(); idle(); step();
    lookup("nt_keep", 32'h1400, 1'b1, 1'b1, 32'h3000, 32'h3000);
    lookup("pc_zero", 32'h0,    1'b1, 1'b0, 32'h0, 32'h4);
    lookup("wrap",    32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 32'h0);

    // Back-to-back updates to one PC: last target wins
    resolve(1'b1, 32'h2004, 32'hA000);
    step();
    resolve(1'b1, 32'h2004, 32'hB000);
    step(); idle(); step();
    lookup("b2b_last", 32'h2004, 1'b1, 1'b1, 32'hB000, 32'hB000);
    lookup("b2b_other", 32'h1400, 1'b0, 1'b1, 32'h3000, 32'h1404);

    // Reset between capture and commit discards the pending entry
    resolve(1'b1, 32'h1800, 32'h5000);
    step(); idle();
    rstn = 1'b0;
    #2;
    lookup("midrst_low", 32'h1400, 1'b1, 1'b0, 32'h0, 32'h1404);
    rstn = 1'b1;
    step(); step();
    lookup("midrst_new", 32'h1800, 1'b1, 1'b0, 32'h0, 32'h1804);
    lookup("midrst_old", 32'h1400, 1'b1, 1'b0, 32'h0, 32'h1404);
    lookup("midrst_b2b", 32'h2004, 1'b1, 1'b0, 32'h0, 32'h2008);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
